// File: rtl/mips_cpu_multdiv.sv
// Iterative HI/LO multiply-divide unit: shift-add multiply and restoring divide,
// 32 iterations followed by one sign-fix cycle, plus direct MTHI/MTLO writes.
module mips_cpu_multdiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_acc;
  logic [WIDTH-1:0] r_opnd;
  logic             r_mul;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_idle;
  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_last;
  logic [WIDTH:0]   w_mul_sum;
  logic [DW-1:0]    w_mul_step;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [DW-1:0]    w_div_step;
  logic [DW-1:0]    w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // Operand conditioning: magnitudes for signed ops, raw values otherwise
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && start && (op[2] == 1'b0);
  assign w_a_neg  = op[0] & op_a[WIDTH-1];
  assign w_b_neg  = op[0] & op_b[WIDTH-1];
  assign w_abs_a  = w_a_neg ? WIDTH'(-op_a) : op_a;
  assign w_abs_b  = w_b_neg ? WIDTH'(-op_b) : op_b;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // One multiply step: add multiplicand on multiplier LSB, shift right
  assign w_mul_sum  = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring-divide step: partial remainder in upper half, quotient shifts into lower
  assign w_rem_sh   = {r_acc[DW-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_step = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in the fix cycle
  assign w_prod = r_neg_q ? DW'(-r_acc) : r_acc;
  assign w_quot = r_div0  ? '1
                : (r_neg_q ? WIDTH'(-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0]);
  assign w_rem  = r_neg_r ? WIDTH'(-r_acc[DW-1:WIDTH]) : r_acc[DW-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC:  if (w_last)   w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO writes and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_mul   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_mul   <= ~op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div0  <= op[1] && (op_b == '0);
            r_busy  <= 1'b1;
            if (op[1]) begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
              r_opnd <= w_abs_b;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
              r_opnd <= w_abs_a;
            end
          end else if (start && op == 3'd4) begin
            r_hi <= op_a;
          end else if (start && op == 3'd5) begin
            r_lo <= op_a;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= r_mul ? w_mul_step : w_div_step;
        end
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_mul) begin
            r_hi <= w_prod[DW-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
